// File: rtl/vga_fill_arbiter_pkg.sv
// Shared video RAM geometry, colour constants and fill FSM encoding.
package VGADefs;

    localparam int DATA_WIDTH = 3;
    localparam int ADDR_WIDTH = 11;
    localparam int MEM_WIDTH  = 40;
    localparam int MEM_HEIGHT = 30;
    localparam int XW         = 6;
    localparam int YW         = 5;

    localparam logic [DATA_WIDTH-1:0] BLACK   = 3'b000;
    localparam logic [DATA_WIDTH-1:0] BLUE    = 3'b001;
    localparam logic [DATA_WIDTH-1:0] GREEN   = 3'b010;
    localparam logic [DATA_WIDTH-1:0] CYAN    = 3'b011;
    localparam logic [DATA_WIDTH-1:0] RED     = 3'b100;
    localparam logic [DATA_WIDTH-1:0] MAGENTA = 3'b101;
    localparam logic [DATA_WIDTH-1:0] YELLOW  = 3'b110;
    localparam logic [DATA_WIDTH-1:0] WHITE   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/vga_fill_counter.sv
// Raster-order column/row walker for the fill engine: clips the rectangle
// to the screen on load and produces the current cell address.
module vga_fill_counter
    import VGADefs::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [XW-1:0]         x_i,
    input  logic [YW-1:0]         y_i,
    input  logic [XW-1:0]         w_i,
    input  logic [YW-1:0]         h_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  empty_o
);

    localparam logic [XW-1:0]         MEM_W_X  = XW'(MEM_WIDTH);
    localparam logic [YW-1:0]         MEM_H_Y  = YW'(MEM_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(MEM_WIDTH);

    logic [XW-1:0]         col_q, col_d, eff_w_q, eff_w_d;
    logic [YW-1:0]         row_q, row_d, eff_h_q, eff_h_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [XW-1:0]         rem_w;
    logic [YW-1:0]         rem_h;
    logic                  row_end;

    // Remaining room right of / below the origin; only meaningful when the
    // origin is on screen, which empty_o guarantees before a load.
    assign empty_o = (x_i >= MEM_W_X) || (y_i >= MEM_H_Y) || (w_i == '0) || (h_i == '0);
    assign rem_w   = MEM_W_X - x_i;
    assign rem_h   = MEM_H_Y - y_i;
    assign row_end = (col_q == eff_w_q - XW'(1));
    assign last_o  = row_end && (row_q == eff_h_q - YW'(1));
    assign addr_o  = row_base_q + ADDR_WIDTH'(col_q);

    // Next-state: clip and seed on load, advance one cell per step.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        col_d      = col_q;
        row_d      = row_q;
        eff_w_d    = eff_w_q;
        eff_h_d    = eff_h_q;
        row_base_d = row_base_q;
        if (load_i) begin
            col_d      = '0;
            row_d      = '0;
            eff_w_d    = (w_i < rem_w) ? w_i : rem_w;
            eff_h_d    = (h_i < rem_h) ? h_i : rem_h;
            // Y*40 as Y*32 + Y*8, no multiplier.
            row_base_d = ADDR_WIDTH'({y_i, 5'b0}) + ADDR_WIDTH'({y_i, 3'b0}) + ADDR_WIDTH'(x_i);
        end else if (step_i) begin
            if (row_end) begin
                col_d      = '0;
                row_d      = row_q + YW'(1);
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                col_d = col_q + XW'(1);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col_q      <= '0;
            row_q      <= '0;
            eff_w_q    <= '0;
            eff_h_q    <= '0;
            row_base_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together at the edge.
            col_q      <= col_d;
            row_q      <= row_d;
            eff_w_q    <= eff_w_d;
            eff_h_q    <= eff_h_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/vga_fill_arbiter.sv
// Video RAM write-port owner: CPU writes have fixed priority, the rectangle
// fill engine uses every otherwise idle cycle. All outputs are registered.
module vga_fill_arbiter
    import VGADefs::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCpuWrite,
    input  logic [ADDR_WIDTH-1:0] iCpuAddr,
    input  logic [DATA_WIDTH-1:0] iCpuData,
    input  logic                  iFillStart,
    input  logic [XW-1:0]         iFillX,
    input  logic [YW-1:0]         iFillY,
    input  logic [XW-1:0]         iFillW,
    input  logic [YW-1:0]         iFillH,
    input  logic [DATA_WIDTH-1:0] iFillColor,
    input  logic                  iFillAbort,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    output logic                  oFillBusy,
    output logic                  oFillDone
);

    fill_state_e           state_q, state_d;
    logic [XW-1:0]         fill_x_q, fill_w_q;
    logic [YW-1:0]         fill_y_q, fill_h_q;
    logic [DATA_WIDTH-1:0] fill_color_q;

    logic                  latch_cmd, cnt_load, cnt_step, fill_wr;
    logic                  cnt_last, cnt_empty;
    logic [ADDR_WIDTH-1:0] cnt_addr;

    logic                  we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    vga_fill_counter u_counter (
        .Clock   (Clock),
        .Reset   (Reset),
        .load_i  (cnt_load),
        .step_i  (cnt_step),
        .x_i     (fill_x_q),
        .y_i     (fill_y_q),
        .w_i     (fill_w_q),
        .h_i     (fill_h_q),
        .addr_o  (cnt_addr),
        .last_o  (cnt_last),
        .empty_o (cnt_empty)
    );

    // Fill FSM next state, counter control and write-port arbitration.
    always_comb begin
        state_d   = state_q;
        latch_cmd = 1'b0;
        cnt_load  = 1'b0;
        cnt_step  = 1'b0;
        fill_wr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iFillStart) begin
                    latch_cmd = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (iFillAbort || cnt_empty) begin
                    state_d = DONE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                // A CPU write steals the slot; the counters simply hold.
                if (!iCpuWrite) begin
                    fill_wr  = 1'b1;
                    cnt_step = 1'b1;
                    if (cnt_last) begin
                        state_d = DONE;
                    end
                end
                if (iFillAbort) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        we_d   = iCpuWrite || fill_wr;
        addr_d = '0;
        data_d = '0;
        if (iCpuWrite) begin
            addr_d = iCpuAddr;
            data_d = iCpuData;
        end else if (fill_wr) begin
            addr_d = cnt_addr;
            data_d = fill_color_q;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    // State, captured command and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            fill_x_q     <= '0;
            fill_y_q     <= '0;
            fill_w_q     <= '0;
            fill_h_q     <= '0;
            fill_color_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_cmd) begin
                fill_x_q     <= iFillX;
                fill_y_q     <= iFillY;
                fill_w_q     <= iFillW;
                fill_h_q     <= iFillH;
                fill_color_q <= iFillColor;
            end
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oWriteData    = data_q;
    assign oFillBusy     = busy_q;
    assign oFillDone     = done_q;

endmodule

// File: tb/tb_vga_fill_arbiter.sv
// Scoreboard bench for vga_fill_arbiter: expected writes are queued as
// stimulus is issued and popped by a write-port monitor.
module tb_vga_fill_arbiter;
    import VGADefs::*;

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic                  iCpuWrite;
    logic [ADDR_WIDTH-1:0] iCpuAddr;
    logic [DATA_WIDTH-1:0] iCpuData;
    logic                  iFillStart;
    logic [XW-1:0]         iFillX;
    logic [YW-1:0]         iFillY;
    logic [XW-1:0]         iFillW;
    logic [YW-1:0]         iFillH;
    logic [DATA_WIDTH-1:0] iFillColor;
    logic                  iFillAbort;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [DATA_WIDTH-1:0] oWriteData;
    logic                  oFillBusy;
    logic                  oFillDone;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    vga_fill_arbiter dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iCpuWrite     (iCpuWrite),
        .iCpuAddr      (iCpuAddr),
        .iCpuData      (iCpuData),
        .iFillStart    (iFillStart),
        .iFillX        (iFillX),
        .iFillY        (iFillY),
        .iFillW        (iFillW),
        .iFillH        (iFillH),
        .iFillColor    (iFillColor),
        .iFillAbort    (iFillAbort),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oWriteData    (oWriteData),
        .oFillBusy     (oFillBusy),
        .oFillDone     (oFillDone)
    );

    always #5 Clock = ~Clock;

    // Write-port monitor: every write must match the head of the queue.
    always @(negedge Clock) begin
        wr_t e;
        if (!Reset && oWriteEnable) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got addr=%0d data=%0d, required no write",
                         oWriteAddress, oWriteData);
            end else begin
                e = exp_q.pop_front();
                if (oWriteAddress !== e.addr || oWriteData !== e.data) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             oWriteAddress, oWriteData, e.addr, e.data);
                end
            end
        end
    end

    function automatic void push_wr(input int a, input int d);
        wr_t e;
        e.addr = ADDR_WIDTH'(a);
        e.data = DATA_WIDTH'(d);
        exp_q.push_back(e);
    endfunction

    // Reference model of a clipped raster fill.
    function automatic void push_rect(input int x, input int y, input int w, input int h, input int c);
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++)
                if (x + k < MEM_WIDTH && y + r < MEM_HEIGHT)
                    push_wr((y + r) * MEM_WIDTH + x + k, c);
    endfunction

    task automatic idle_inputs();
        iCpuWrite  = 1'b0;
        iCpuAddr   = '0;
        iCpuData   = '0;
        iFillStart = 1'b0;
        iFillAbort = 1'b0;
    endtask

    // Issues a fill and records per-cycle observations. Cycle n is the n-th
    // cycle after the edge that samples iFillStart.
    task automatic run_fill(input int x, input int y, input int w, input int h, input int col,
                            input int cpu_n, input int cpu_addr, input int cpu_data,
                            input int abort_n, input int restart_n,
                            output int busy_cnt, output int wr_cnt, output int done_cnt,
                            output int done_n, output int first_wr_n, output int last_wr_n);
        busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
        done_n = -1; first_wr_n = -1; last_wr_n = -1;
        iFillX = XW'(x); iFillY = YW'(y); iFillW = XW'(w); iFillH = YW'(h);
        iFillColor = DATA_WIDTH'(col);
        iFillStart = 1'b1;
        @(posedge Clock); #1;
        for (int n = 1; n <= 1400; n++) begin
            iFillStart = (n == restart_n);
            iFillAbort = (n == abort_n);
            iCpuWrite  = (n == cpu_n);
            iCpuAddr   = ADDR_WIDTH'(cpu_addr);
            iCpuData   = DATA_WIDTH'(cpu_data);
            @(negedge Clock);
            if (oFillBusy) busy_cnt++;
            if (oWriteEnable) begin
                wr_cnt++;
                if (first_wr_n < 0) first_wr_n = n;
                last_wr_n = n;
            end
            if (oFillDone) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            @(posedge Clock); #1;
            if (done_n >= 0 && n >= done_n + 2) break;
        end
        idle_inputs();
        total++;
        if (done_n < 0) begin
            bad++;
            $display("FAIL fill_timeout: oFillDone never seen, required a pulse");
        end
    endtask

    task automatic check_queue_empty(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: %0d writes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        iFillX = '0; iFillY = '0; iFillW = '0; iFillH = '0; iFillColor = '0;
        #3;
        total++;
        if ({oWriteEnable, oWriteAddress, oWriteData, oFillBusy, oFillDone} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%0d busy=%b done=%b, required all 0",
                     oWriteEnable, oWriteAddress, oWriteData, oFillBusy, oFillDone);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic test_basic();
        int busy, wr, dn, dn_n, f, l;
        foreach (push_list_basic[i]) push_wr(push_list_basic[i], 4);
        run_fill(2, 1, 3, 2, 4, -1, 0, 0, -1, -1, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 6) begin bad++; $display("FAIL basic_writes: got %0d, required 6", wr); end
        total++; if (l - f !== 5) begin bad++; $display("FAIL basic_burst: got span %0d, required 5", l - f); end
        total++; if (busy !== 8) begin bad++; $display("FAIL basic_busy: got %0d cycles, required 8", busy); end
        total++; if (dn !== 1) begin bad++; $display("FAIL basic_done_count: got %0d, required 1", dn); end
        total++; if (dn_n !== l + 1) begin bad++; $display("FAIL basic_done_time: got cycle %0d, required %0d", dn_n, l + 1); end
        check_queue_empty("basic");
    endtask

    int push_list_basic[6] = '{42, 43, 44, 82, 83, 84};

    task automatic test_cpu_priority();
        int busy, wr, dn, dn_n, f, l;
        push_wr(42, 4);
        push_wr(500, 2);
        foreach (push_list_basic[i]) if (i > 0) push_wr(push_list_basic[i], 4);
        run_fill(2, 1, 3, 2, 4, 3, 500, 2, -1, -1, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 7) begin bad++; $display("FAIL cpu_writes: got %0d, required 7", wr); end
        total++; if (l - f !== 6) begin bad++; $display("FAIL cpu_burst: got span %0d, required 6", l - f); end
        total++; if (dn !== 1) begin bad++; $display("FAIL cpu_done_count: got %0d, required 1", dn); end
        check_queue_empty("cpu");
    endtask

    task automatic test_clip();
        int busy, wr, dn, dn_n, f, l;
        push_wr(1198, 7);
        push_wr(1199, 7);
        run_fill(38, 29, 5, 4, 7, -1, 0, 0, -1, -1, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 2) begin bad++; $display("FAIL clip_writes: got %0d, required 2", wr); end
        total++; if (dn_n !== l + 1) begin bad++; $display("FAIL clip_done_time: got cycle %0d, required %0d", dn_n, l + 1); end
        check_queue_empty("clip");
        push_rect(35, 27, 10, 10, 3);
        run_fill(35, 27, 10, 10, 3, -1, 0, 0, -1, -1, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 15) begin bad++; $display("FAIL clip2_writes: got %0d, required 15", wr); end
        check_queue_empty("clip2");
    endtask

    task automatic test_degenerate();
        int busy, wr, dn, dn_n, f, l;
        int cases[4][4] = '{'{5, 5, 0, 3}, '{40, 0, 3, 3}, '{0, 30, 3, 3}, '{1, 1, 4, 0}};
        for (int i = 0; i < 4; i++) begin
            run_fill(cases[i][0], cases[i][1], cases[i][2], cases[i][3], 6, -1, 0, 0, -1, -1,
                     busy, wr, dn, dn_n, f, l);
            total++; if (wr !== 0) begin bad++; $display("FAIL degen%0d_writes: got %0d, required 0", i, wr); end
            total++; if (dn_n !== 3) begin bad++; $display("FAIL degen%0d_done_time: got cycle %0d, required 3", i, dn_n); end
        end
    endtask

    task automatic test_abort();
        int busy, wr, dn, dn_n, f, l;
        push_wr(0, 5); push_wr(1, 5); push_wr(2, 5);
        run_fill(0, 0, 40, 30, 5, -1, 0, 0, 4, 3, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 3) begin bad++; $display("FAIL abort_writes: got %0d, required 3", wr); end
        total++; if (dn !== 1) begin bad++; $display("FAIL abort_done_count: got %0d, required 1", dn); end
        total++; if (dn_n !== l + 1) begin bad++; $display("FAIL abort_done_time: got cycle %0d, required %0d", dn_n, l + 1); end
        check_queue_empty("abort");
        // Abort while still in SETUP: no writes at all.
        run_fill(0, 0, 40, 30, 5, -1, 0, 0, 1, -1, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 0) begin bad++; $display("FAIL abort_setup_writes: got %0d, required 0", wr); end
    endtask

    task automatic test_cpu_idle();
        push_wr(1500, 6);
        iCpuWrite = 1'b1; iCpuAddr = ADDR_WIDTH'(1500); iCpuData = 3'b110;
        @(posedge Clock); #1;
        idle_inputs();
        @(negedge Clock);
        total++;
        if (oWriteEnable !== 1'b1 || oFillBusy !== 1'b0) begin
            bad++;
            $display("FAIL cpu_idle: got we=%b busy=%b, required we=1 busy=0", oWriteEnable, oFillBusy);
        end
        @(posedge Clock); #1;
        check_queue_empty("cpu_idle");
    endtask

    task automatic test_reset_mid_fill();
        int busy, wr, dn, dn_n, f, l;
        int seen_done = 0;
        push_rect(0, 0, 40, 30, 1);
        iFillX = '0; iFillY = '0; iFillW = XW'(40); iFillH = YW'(30); iFillColor = 3'b001;
        iFillStart = 1'b1;
        @(posedge Clock); #1;
        iFillStart = 1'b0;
        repeat (20) begin @(posedge Clock); #1; end
        Reset = 1'b1;
        #1;
        total++;
        if (oWriteEnable !== 1'b0 || oFillBusy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got we=%b busy=%b, required 0 0", oWriteEnable, oFillBusy);
        end
        exp_q.delete();
        @(posedge Clock); #1;
        Reset = 1'b0;
        repeat (5) begin
            @(negedge Clock);
            if (oFillDone || oWriteEnable || oFillBusy) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin
            bad++;
            $display("FAIL rst_mid_quiet: got %0d active cycles after reset, required 0", seen_done);
        end
        @(posedge Clock); #1;
        push_rect(10, 3, 2, 2, 2);
        run_fill(10, 3, 2, 2, 2, -1, 0, 0, -1, -1, busy, wr, dn, dn_n, f, l);
        total++; if (wr !== 4) begin bad++; $display("FAIL rst_refill_writes: got %0d, required 4", wr); end
        total++; if (busy !== 6) begin bad++; $display("FAIL rst_refill_busy: got %0d, required 6", busy); end
        check_queue_empty("rst_refill");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cpu_priority();
        test_clip();
        test_degenerate();
        test_abort();
        test_cpu_idle();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fill_arbiter.md
Name: vga_fill_arbiter

Overview:
- Owns the single write port of the video RAM (40x30 cells, 3-bit colour) and shares it between two requesters: the CPU `VGA` instruction path and a hardware rectangle-fill engine.
- The fill engine writes one cell per cycle in raster order.
- CPU writes always take priority; the fill engine stalls on any cycle the CPU writes.
- Sits between the MiniAlu execute stage and VGARam; the CPU may poll oFillBusy through a status register.

Parameters:
- DATA_WIDTH, 3, colour bits per cell
- ADDR_WIDTH, 11, video RAM address width
- MEM_WIDTH, 40, cells per row
- MEM_HEIGHT, 30, rows
- XW, 6, width of X/W coordinates
- YW, 5, width of Y/H coordinates

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- iCpuWrite  in  1  CPU write request, single cycle
- iCpuAddr  in  ADDR_WIDTH  CPU write address
- iCpuData  in  DATA_WIDTH  CPU write colour
- iFillStart  in  1  pulse; latches the fill command
- iFillX  in  XW  rectangle left column
- iFillY  in  YW  rectangle top row
- iFillW  in  XW  rectangle width in cells
- iFillH  in  YW  rectangle height in rows
- iFillColor  in  DATA_WIDTH  fill colour
- iFillAbort  in  1  pulse; cancel the fill in progress
- oWriteEnable  out  1  to VGARam iWriteEnable
- oWriteAddress  out  ADDR_WIDTH  to VGARam iWriteAddress
- oWriteData  out  DATA_WIDTH  to VGARam iDataIn
- oFillBusy  out  1  fill engine active
- oFillDone  out  1  one-cycle pulse when a fill completes or is aborted

Behaviour:
- Clock is a single clock; reset is asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; all internal counters 0.
- All outputs are registered. A write requested or scheduled in cycle n appears on the write port in cycle n+1.
- FSM states: IDLE, SETUP, FILL, DONE.

IDLE:
- oFillBusy=0.
- iFillStart latches X, Y, W, H and colour, then goes to SETUP.
- iFillStart in any other state is ignored.

SETUP (one cycle):
- If X>=MEM_WIDTH, Y>=MEM_HEIGHT, W==0 or H==0, go to DONE with no writes.
- Otherwise:
  - effW = min(W, MEM_WIDTH-X)
  - effH = min(H, MEM_HEIGHT-Y)
  - rowBase = Y*MEM_WIDTH + X, computed by shift-add with no multiplier instance
  - col = 0, row = 0
  - go to FILL.
- oFillBusy=1 from SETUP through DONE inclusive.

FILL:
- Each cycle with iCpuWrite=0: emit a write of colour to address rowBase+col, then col++.
- When col==effW-1: col=0, row++, rowBase += MEM_WIDTH.
- After the write at (effW-1, effH-1), go to DONE.
- Each cycle with iCpuWrite=1: emit the CPU write instead. The fill counters hold and no fill write is lost.

DONE (one cycle):
- oFillDone=1, then return to IDLE.

Arbitration:
- The CPU has fixed priority and is never stalled.
- Fill throughput is one cell per cycle when there is no CPU traffic.
- CPU writes pass through in every state, including IDLE and SETUP.

Abort:
- iFillAbort in SETUP or FILL goes to DONE next cycle, with no further fill writes after the abort cycle.
- In IDLE or DONE, iFillAbort has no effect.
- iFillAbort together with iFillStart in IDLE: the start wins.

Addressing:
- CPU addresses are passed unchecked.
- Fill addresses never exceed MEM_WIDTH*MEM_HEIGHT-1 because of clipping.
- All address arithmetic is ADDR_WIDTH wide with no wrap.

Reset mid-fill:
- Returns immediately to IDLE with outputs 0. No oFillDone pulse.

Decomposition:
- Shared package `VGADefs`: MEM_WIDTH, MEM_HEIGHT, ADDR_WIDTH, DATA_WIDTH, colour constants (BLACK=3'b000 … WHITE=3'b111) and the FSM state encoding.
- One natural sub-module, `vga_fill_counter`: the col/row counter with clipping compare and rowBase accumulation. The top level keeps the arbitration mux and the FSM.

Test Plan:
- Reset asserted mid-FILL (X=0, Y=0, W=40, H=30) -> next edge: oWriteEnable=0, oFillBusy=0; no oFillDone; a following fill works normally.
- Fill X=2, Y=1, W=3, H=2, colour=3'b100, no CPU traffic -> writes to addresses 42, 43, 44, 82, 83, 84 on consecutive cycles, data 4; oFillDone pulses once, 1 cycle after the last write; oFillBusy high for 8 cycles.
- Same fill with iCpuWrite=1 (addr 500, data 3'b010) on the 2nd fill cycle -> write at 500/2 appears in the 2nd write slot; fill addresses continue 43, 44, 82, 83, 84 with no gap or duplicate; total 7 writes.
- Clipped fill X=38, Y=29, W=5, H=4 -> exactly two writes, to addresses 1198 and 1199, then oFillDone.
- Degenerate fill W=0 (or X=40) -> zero writes; oFillDone pulses 2 cycles after iFillStart.
- Abort on the 3rd FILL cycle of a 40x30 fill -> exactly 3 fill writes (0, 1, 2); oFillDone next cycle; a second iFillStart issued during busy is ignored.
